// File: rtl/ps2_pkg.sv
// Shared scan codes, decoder/move enums and small helpers for the PS/2 WASD controller.
package ps2_pkg;

  localparam logic [7:0] KEY_W      = 8'h1D;
  localparam logic [7:0] KEY_A      = 8'h1C;
  localparam logic [7:0] KEY_S      = 8'h1B;
  localparam logic [7:0] KEY_D      = 8'h23;
  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BREAK     = 2'd1,
    EXT       = 2'd2,
    EXT_BREAK = 2'd3
  } decode_state_t;

  typedef enum logic [1:0] {
    NEG  = 2'd0,
    POS  = 2'd1,
    STOP = 2'd2
  } move_t;

  // Odd parity holds when data bits plus the parity bit contain an odd number of ones.
  function automatic logic oddParityOk(input logic [7:0] data, input logic parityBit);
    return ^{data, parityBit};
  endfunction

  // Resolve one axis from its two opposing held keys; the most recently pressed key wins a tie.
  function automatic move_t arbitrate(input logic negHeld, input logic posHeld, input move_t last);
    move_t result;
    case ({posHeld, negHeld})
      2'b01:   result = NEG;
      2'b10:   result = POS;
      2'b11:   result = last;
      default: result = STOP;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises the raw lines, samples data on falling clock
// edges, checks start/parity/stop and discards stalled partial frames.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic       ps2Clock,
  input  logic       ps2Data,
  output logic       byteValid,
  output logic [7:0] byteData,
  output logic       frameError
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_SAT  = CW'(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0] clkSync_r;
  logic [SYNC_STAGES-1:0] dataSync_r;
  logic                   clkPrev_r;
  logic [3:0]             bitCount_r;
  logic [9:0]             shift_r;
  logic [CW-1:0]          idleCount_r;
  logic                   byteValid_r;
  logic [7:0]             byteData_r;
  logic                   frameError_r;
  logic                   fallEdge_s;
  logic                   dataBit_s;
  logic                   frameGood_s;

  // Bring the asynchronous PS/2 lines into the clock domain; idle level of both lines is high.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      clkSync_r  <= '1;
      dataSync_r <= '1;
      clkPrev_r  <= 1'b1;
    end else begin
      clkSync_r  <= {clkSync_r[SYNC_STAGES-2:0], ps2Clock};
      dataSync_r <= {dataSync_r[SYNC_STAGES-2:0], ps2Data};
      clkPrev_r  <= clkSync_r[SYNC_STAGES-1];
    end
  end

  assign fallEdge_s = clkPrev_r & ~clkSync_r[SYNC_STAGES-1];
  assign dataBit_s  = dataSync_r[SYNC_STAGES-1];

  // shift_r holds start in [0], data in [8:1], parity in [9]; the stop bit is the live sample.
  assign frameGood_s = (shift_r[0] == 1'b0) && oddParityOk(shift_r[8:1], shift_r[9]) && dataBit_s;

  // Bit collection, frame checking and stall timeout; a falling edge takes priority over the timeout.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      bitCount_r   <= 4'd0;
      shift_r      <= 10'd0;
      idleCount_r  <= '0;
      byteValid_r  <= 1'b0;
      byteData_r   <= 8'd0;
      frameError_r <= 1'b0;
    end else begin
      byteValid_r  <= 1'b0;
      frameError_r <= 1'b0;
      if (fallEdge_s) begin
        idleCount_r <= '0;
        if (bitCount_r == 4'd10) begin
          bitCount_r <= 4'd0;
          if (frameGood_s) begin
            byteValid_r <= 1'b1;
            byteData_r  <= shift_r[8:1];
          end else begin
            frameError_r <= 1'b1;
          end
        end else begin
          shift_r    <= {dataBit_s, shift_r[9:1]};
          bitCount_r <= bitCount_r + 4'd1;
        end
      end else if ((bitCount_r != 4'd0) && (idleCount_r == TIMEOUT_LAST)) begin
        frameError_r <= 1'b1;
        bitCount_r   <= 4'd0;
        idleCount_r  <= TIMEOUT_SAT;
      end else if (idleCount_r != TIMEOUT_SAT) begin
        idleCount_r <= idleCount_r + CW'(1);
      end
    end
  end

  assign byteValid  = byteValid_r;
  assign byteData   = byteData_r;
  assign frameError = frameError_r;

endmodule

// File: rtl/ps2_wasd_controller.sv
// PS/2 WASD controller top: scan-code sequencing, held-key tracking and
// opposing-key arbitration into x/y movement codes.
module ps2_wasd_controller
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic       ps2Clock,
  input  logic       ps2Data,
  output logic [1:0] leftRightOutput,
  output logic [1:0] upDownOutput,
  output logic [3:0] keyHeld,
  output logic       frameError
);

  logic          byteValid_s;
  logic [7:0]    byteData_s;
  decode_state_t state_r;
  logic [3:0]    held_r;      // {D,S,A,W}
  move_t         lastV_r;
  move_t         lastH_r;
  move_t         upDown_r;
  move_t         leftRight_r;

  ps2_frame_rx #(
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) frameRx (
    .clock      (clock),
    .resetN     (resetN),
    .ps2Clock   (ps2Clock),
    .ps2Data    (ps2Data),
    .byteValid  (byteValid_s),
    .byteData   (byteData_s),
    .frameError (frameError)
  );

  // Scan-code sequencer: make/break/extended prefixes update held keys and the latest press per axis.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_r <= IDLE;
      held_r  <= 4'b0000;
      lastV_r <= STOP;
      lastH_r <= STOP;
    end else if (byteValid_s) begin
      case (state_r)
        IDLE: begin
          if (byteData_s == CODE_EXT) begin
            state_r <= EXT;
          end else if (byteData_s == CODE_BREAK) begin
            state_r <= BREAK;
          end else begin
            state_r <= IDLE;
            case (byteData_s)
              KEY_W: begin
                held_r[0] <= 1'b1;
                if (!held_r[0]) lastV_r <= NEG;
              end
              KEY_A: begin
                held_r[1] <= 1'b1;
                if (!held_r[1]) lastH_r <= NEG;
              end
              KEY_S: begin
                held_r[2] <= 1'b1;
                if (!held_r[2]) lastV_r <= POS;
              end
              KEY_D: begin
                held_r[3] <= 1'b1;
                if (!held_r[3]) lastH_r <= POS;
              end
              default: ;
            endcase
          end
        end
        BREAK: begin
          state_r <= IDLE;
          case (byteData_s)
            KEY_W:   held_r[0] <= 1'b0;
            KEY_A:   held_r[1] <= 1'b0;
            KEY_S:   held_r[2] <= 1'b0;
            KEY_D:   held_r[3] <= 1'b0;
            default: ;
          endcase
        end
        EXT: begin
          state_r <= (byteData_s == CODE_BREAK) ? EXT_BREAK : IDLE;
        end
        EXT_BREAK: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Registered axis arbitration, following the held-key registers by one clock.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      upDown_r    <= STOP;
      leftRight_r <= STOP;
    end else begin
      upDown_r    <= arbitrate(held_r[0], held_r[2], lastV_r);
      leftRight_r <= arbitrate(held_r[1], held_r[3], lastH_r);
    end
  end

  assign upDownOutput    = upDown_r;
  assign leftRightOutput = leftRight_r;
  assign keyHeld         = held_r;

endmodule

// File: tb/tb_ps2_wasd_controller.sv
// Self-checking bench for ps2_wasd_controller: PS/2 frames are bit-banged onto
// the raw lines and the expected post-frame state is queued and compared.
module tb_ps2_wasd_controller;

  localparam int TIMEOUT = 300;
  localparam int HALF    = 10;   // system clocks per PS/2 half period

  logic       clock;
  logic       resetN;
  logic       ps2Clock;
  logic       ps2Data;
  logic [1:0] leftRightOutput;
  logic [1:0] upDownOutput;
  logic [3:0] keyHeld;
  logic       frameError;

  typedef struct {
    string      tag;
    logic [1:0] ud;
    logic [1:0] lr;
    logic [3:0] held;
    int         errs;
  } exp_t;

  exp_t scoreboard[$];
  int   checks    = 0;
  int   errors    = 0;
  int   expErrors = 0;
  int   errSeen   = 0;

  ps2_wasd_controller #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clock           (clock),
    .resetN          (resetN),
    .ps2Clock        (ps2Clock),
    .ps2Data         (ps2Data),
    .leftRightOutput (leftRightOutput),
    .upDownOutput    (upDownOutput),
    .keyHeld         (keyHeld),
    .frameError      (frameError)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count frameError pulses as they happen.
  always @(posedge clock) begin
    if (frameError === 1'b1) errSeen <= errSeen + 1;
  end

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic ps2Bit(input logic b);
    ps2Data = b;
    waitClk(HALF);
    ps2Clock = 1'b0;
    waitClk(HALF);
    ps2Clock = 1'b1;
  endtask

  function automatic logic [10:0] makeFrame(input logic [7:0] b, input bit badParity);
    logic par;
    par = (~^b) ^ badParity;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic sendBits(input logic [10:0] frame, input int n);
    for (int i = 0; i < n; i++) ps2Bit(frame[i]);
    ps2Data = 1'b1;
  endtask

  task automatic compareHead();
    exp_t e;
    if (scoreboard.size() == 0) begin
      checkVal("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = scoreboard.pop_front();
      checkVal({e.tag, "_ud"},   {30'd0, upDownOutput},    {30'd0, e.ud});
      checkVal({e.tag, "_lr"},   {30'd0, leftRightOutput}, {30'd0, e.lr});
      checkVal({e.tag, "_held"}, {28'd0, keyHeld},         {28'd0, e.held});
      checkVal({e.tag, "_err"},  errSeen,                  e.errs);
    end
  endtask

  // Send one byte, queue the expected state after it decodes, then compare.
  task automatic sendExpect(input string tag, input logic [7:0] b, input bit bad,
                            input logic [1:0] ud, input logic [1:0] lr, input logic [3:0] held);
    exp_t e;
    if (bad) expErrors++;
    e.tag = tag; e.ud = ud; e.lr = lr; e.held = held; e.errs = expErrors;
    scoreboard.push_back(e);
    sendBits(makeFrame(b, bad), 11);
    waitClk(HALF);
    @(negedge clock);
    compareHead();
    waitClk(2 * HALF);
  endtask

  initial begin
    resetN   = 1'b0;
    ps2Clock = 1'b1;
    ps2Data  = 1'b1;
    waitClk(3);
    @(negedge clock);
    checkVal("reset_ud",   {30'd0, upDownOutput},    32'd2);
    checkVal("reset_lr",   {30'd0, leftRightOutput}, 32'd2);
    checkVal("reset_held", {28'd0, keyHeld},         32'd0);
    checkVal("reset_ferr", {31'd0, frameError},      32'd0);
    resetN = 1'b1;
    waitClk(5);

    // W, then S overrides, S release returns to W, W release stops.
    sendExpect("w_make",    8'h1D, 1'b0, 2'd0, 2'd2, 4'b0001);
    sendExpect("s_make",    8'h1B, 1'b0, 2'd1, 2'd2, 4'b0101);
    sendExpect("s_brk_pre", 8'hF0, 1'b0, 2'd1, 2'd2, 4'b0101);
    sendExpect("s_brk",     8'h1B, 1'b0, 2'd0, 2'd2, 4'b0001);
    sendExpect("w_brk_pre", 8'hF0, 1'b0, 2'd0, 2'd2, 4'b0001);
    sendExpect("w_brk",     8'h1D, 1'b0, 2'd2, 2'd2, 4'b0000);

    // A typematic repeats, then D; D stays after A release.
    for (int i = 0; i < 5; i++) sendExpect("a_rep", 8'h1C, 1'b0, 2'd2, 2'd0, 4'b0010);
    sendExpect("d_make",    8'h23, 1'b0, 2'd2, 2'd1, 4'b1010);
    sendExpect("a_brk_pre", 8'hF0, 1'b0, 2'd2, 2'd1, 4'b1010);
    sendExpect("a_brk",     8'h1C, 1'b0, 2'd2, 2'd1, 4'b1000);
    sendExpect("d_brk_pre", 8'hF0, 1'b0, 2'd2, 2'd1, 4'b1000);
    sendExpect("d_brk",     8'h23, 1'b0, 2'd2, 2'd2, 4'b0000);

    // Bad parity is dropped with one error pulse; a later release of an unheld key is harmless.
    sendExpect("bad_par",   8'h1D, 1'b1, 2'd2, 2'd2, 4'b0000);
    sendExpect("nb_pre",    8'hF0, 1'b0, 2'd2, 2'd2, 4'b0000);
    sendExpect("nb_w",      8'h1D, 1'b0, 2'd2, 2'd2, 4'b0000);

    // Extended break of the W code must not release the held W.
    sendExpect("w_make2",   8'h1D, 1'b0, 2'd0, 2'd2, 4'b0001);
    sendExpect("ext_pre",   8'hE0, 1'b0, 2'd0, 2'd2, 4'b0001);
    sendExpect("ext_brk",   8'hF0, 1'b0, 2'd0, 2'd2, 4'b0001);
    sendExpect("ext_w",     8'h1D, 1'b0, 2'd0, 2'd2, 4'b0001);
    sendExpect("w_brk2pre", 8'hF0, 1'b0, 2'd0, 2'd2, 4'b0001);
    sendExpect("w_brk2",    8'h1D, 1'b0, 2'd2, 2'd2, 4'b0000);

    // Partial frame stalls past the timeout, then a clean D frame decodes.
    sendBits(makeFrame(8'h23, 1'b0), 6);
    waitClk(TIMEOUT + 30);
    expErrors++;
    @(negedge clock);
    checkVal("timeout_err", errSeen, expErrors);
    sendExpect("d_after_to", 8'h23, 1'b0, 2'd2, 2'd1, 4'b1000);

    // Reset in the middle of a frame while W and D are held.
    sendExpect("w_pre_rst", 8'h1D, 1'b0, 2'd0, 2'd1, 4'b1001);
    sendBits(makeFrame(8'h1B, 1'b0), 4);
    resetN   = 1'b0;
    ps2Clock = 1'b1;
    ps2Data  = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checkVal("midrst_ud",   {30'd0, upDownOutput},    32'd2);
    checkVal("midrst_lr",   {30'd0, leftRightOutput}, 32'd2);
    checkVal("midrst_held", {28'd0, keyHeld},         32'd0);
    checkVal("midrst_ferr", {31'd0, frameError},      32'd0);
    waitClk(2);
    resetN = 1'b1;
    waitClk(5);
    sendExpect("s_post_rst", 8'h1B, 1'b0, 2'd1, 2'd2, 4'b0100);

    checkVal("scoreboard_drained", scoreboard.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
